// File: rtl/fp_normalize_ctrl.sv
// Post-add/sub normalization controller: counts leading zeros, drives a shared left
// barrel shifter through the Shf* ports and returns a normalized mantissa/exponent pair.
module fp_normalize_ctrl #(
    parameter int DataSize  = 25,
    parameter int ExpSize   = 8,
    parameter int ShiftSize = 5
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [DataSize-1:0]  InMantissa,
    input  logic [ExpSize-1:0]   InExponent,
    output logic [DataSize-1:0]  ShfMantissa,
    output logic [ShiftSize-1:0] ShfShifts,
    input  logic [DataSize-1:0]  ShfAligned,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [DataSize-1:0]  OutMantissa,
    output logic [ExpSize-1:0]   OutExponent,
    output logic                 Zero,
    output logic                 Overflow,
    output logic                 Underflow,
    output logic                 Sticky,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ExpSize:0] ExpMax = {1'b0, {ExpSize{1'b1}}};

    state_t                 state_q, state_d;
    logic [DataSize-1:0]    m_q, m_d;
    logic [ExpSize-1:0]     e_q, e_d;
    logic                   carry_q, carry_d;
    logic [DataSize-1:0]    shf_mantissa_q, shf_mantissa_d;
    logic [ShiftSize-1:0]   shf_shifts_q, shf_shifts_d;
    logic [DataSize-1:0]    out_mantissa_q, out_mantissa_d;
    logic [ExpSize-1:0]     out_exponent_q, out_exponent_d;
    logic                   zero_q, zero_d;
    logic                   overflow_q, overflow_d;
    logic                   underflow_q, underflow_d;
    logic                   sticky_q, sticky_d;

    logic [ShiftSize-1:0]   lz;
    logic [ExpSize:0]       e_ext;
    logic [ExpSize:0]       e_inc;
    logic [ExpSize:0]       lz_ext;

    // Both handshakes transfer on a rising edge where valid and ready are both high;
    // valid never depends on ready, and InReady/OutValid are pure state decodes.
    assign InReady     = (state_q == IDLE);
    assign OutValid    = (state_q == DONE);
    assign ShfMantissa = shf_mantissa_q;
    assign ShfShifts   = shf_shifts_q;
    assign OutMantissa = out_mantissa_q;
    assign OutExponent = out_exponent_q;
    assign Zero        = zero_q;
    assign Overflow    = overflow_q;
    assign Underflow   = underflow_q;
    assign Sticky      = sticky_q;
    assign dbg_state   = state_q;

    always_comb begin
        lz = ShiftSize'(DataSize - 1);
        // Ascending scan: the highest set bit is the last one to overwrite lz.
        for (int i = 0; i < DataSize - 1; i++) begin
            if (m_q[i]) begin
                lz = ShiftSize'(DataSize - 2 - i);
            end
        end
        e_ext  = {1'b0, e_q};
        e_inc  = e_ext + 1'b1;
        lz_ext = (ExpSize + 1)'(lz);
    end

    always_comb begin
        state_d        = state_q;
        m_d            = m_q;
        e_d            = e_q;
        carry_d        = carry_q;
        shf_mantissa_d = shf_mantissa_q;
        shf_shifts_d   = shf_shifts_q;
        out_mantissa_d = out_mantissa_q;
        out_exponent_d = out_exponent_q;
        zero_d         = zero_q;
        overflow_d     = overflow_q;
        underflow_d    = underflow_q;
        sticky_d       = sticky_q;

        case (state_q)
            IDLE: begin
                if (InValid) begin
                    m_d         = InMantissa;
                    e_d         = InExponent;
                    zero_d      = 1'b0;
                    overflow_d  = 1'b0;
                    underflow_d = 1'b0;
                    sticky_d    = 1'b0;
                    state_d     = COUNT;
                end
            end
            COUNT: begin
                state_d        = SHIFT;
                shf_mantissa_d = m_q;
                carry_d        = 1'b0;
                if (m_q == '0) begin
                    zero_d         = 1'b1;
                    shf_shifts_d   = '0;
                    out_exponent_d = '0;
                end else if (m_q[DataSize-1]) begin
                    carry_d      = 1'b1;
                    shf_shifts_d = '0;
                    if (e_inc >= ExpMax) begin
                        overflow_d     = 1'b1;
                        out_exponent_d = '1;
                    end else begin
                        out_exponent_d = e_inc[ExpSize-1:0];
                    end
                end else if (lz_ext < e_ext) begin
                    shf_shifts_d   = lz;
                    out_exponent_d = ExpSize'(e_ext - lz_ext);
                end else begin
                    // Exponent runs out first: shift only down to the subnormal position.
                    underflow_d    = 1'b1;
                    shf_shifts_d   = (e_q == '0) ? '0 : ShiftSize'(e_q - 1'b1);
                    out_exponent_d = '0;
                end
            end
            SHIFT: begin
                state_d = DONE;
                if (overflow_q) begin
                    out_mantissa_d = '0;
                    sticky_d       = 1'b0;
                end else if (carry_q) begin
                    out_mantissa_d = {1'b0, shf_mantissa_q[DataSize-1:1]};
                    sticky_d       = shf_mantissa_q[0];
                end else begin
                    out_mantissa_d = ShfAligned;
                end
            end
            DONE: begin
                if (OutReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q        <= IDLE;
            m_q            <= '0;
            e_q            <= '0;
            carry_q        <= 1'b0;
            shf_mantissa_q <= '0;
            shf_shifts_q   <= '0;
            out_mantissa_q <= '0;
            out_exponent_q <= '0;
            zero_q         <= 1'b0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            sticky_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            m_q            <= m_d;
            e_q            <= e_d;
            carry_q        <= carry_d;
            shf_mantissa_q <= shf_mantissa_d;
            shf_shifts_q   <= shf_shifts_d;
            out_mantissa_q <= out_mantissa_d;
            out_exponent_q <= out_exponent_d;
            zero_q         <= zero_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
            sticky_q       <= sticky_d;
        end
    end

endmodule

// File: tb/tb_fp_normalize_ctrl.sv
// Bench for fp_normalize_ctrl: hand-computed vector table, reset/hold corner sequences
// and random operations checked against a behavioural model through an expected queue.
module tb_fp_normalize_ctrl;

    localparam int W = 42;  // {mant[25], exp[8], zero, ovf, unf, sticky, shifts[5]}

    logic        Clk;
    logic        Reset;
    logic        InValid;
    logic        InReady;
    logic [24:0] InMantissa;
    logic [7:0]  InExponent;
    logic [24:0] ShfMantissa;
    logic [4:0]  ShfShifts;
    logic [24:0] ShfAligned;
    logic        OutValid;
    logic        OutReady;
    logic [24:0] OutMantissa;
    logic [7:0]  OutExponent;
    logic        Zero;
    logic        Overflow;
    logic        Underflow;
    logic        Sticky;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [24:0] m;
        logic [7:0]  e;
        logic [24:0] mant;
        logic [7:0]  ex;
        logic        z;
        logic        o;
        logic        u;
        logic        s;
        logic [4:0]  sh;
    } vec_t;

    vec_t tbl[14];

    fp_normalize_ctrl dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .InValid     (InValid),
        .InReady     (InReady),
        .InMantissa  (InMantissa),
        .InExponent  (InExponent),
        .ShfMantissa (ShfMantissa),
        .ShfShifts   (ShfShifts),
        .ShfAligned  (ShfAligned),
        .OutValid    (OutValid),
        .OutReady    (OutReady),
        .OutMantissa (OutMantissa),
        .OutExponent (OutExponent),
        .Zero        (Zero),
        .Overflow    (Overflow),
        .Underflow   (Underflow),
        .Sticky      (Sticky),
        .dbg_state   (dbg_state)
    );

    // shared combinational left barrel shifter
    assign ShfAligned = ShfMantissa << ShfShifts;

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] dut_out();
        return {OutMantissa, OutExponent, Zero, Overflow, Underflow, Sticky, ShfShifts};
    endfunction

    function automatic logic [W-1:0] pack(input vec_t v);
        return {v.mant, v.ex, v.z, v.o, v.u, v.s, v.sh};
    endfunction

    function automatic logic [W-1:0] model(input logic [24:0] m, input logic [7:0] e);
        int lz;
        int ex;
        int s;
        logic [23:0] t;
        logic [24:0] mant;
        logic z, o, u, st;
        lz = 0;
        t = m[23:0];
        while (lz < 24 && !t[23]) begin
            t = t << 1;
            lz++;
        end
        z = 0; o = 0; u = 0; st = 0; s = 0; ex = 0; mant = '0;
        if (m == 0) begin
            z = 1;
        end else if (m[24]) begin
            if (int'(e) + 1 >= 255) begin
                o = 1;
                ex = 255;
            end else begin
                ex = int'(e) + 1;
                mant = m >> 1;
                st = m[0];
            end
        end else if (lz < int'(e)) begin
            s = lz;
            ex = int'(e) - lz;
            mant = m << s;
        end else begin
            u = 1;
            s = (e == 0) ? 0 : int'(e) - 1;
            mant = m << s;
        end
        return {mant, 8'(ex), z, o, u, st, 5'(s)};
    endfunction

    // driver: one operation, output held for `hold` cycles before acceptance
    task automatic do_op(input logic [24:0] m, input logic [7:0] e,
                         input logic [W-1:0] expv, input int hold);
        int n;
        n = 0;
        while (!InReady && n < 20) begin
            @(negedge Clk);
            n++;
        end
        if (!InReady) begin
            chk("in_ready_wait", InReady, 1);
            return;
        end
        InValid    = 1'b1;
        InMantissa = m;
        InExponent = e;
        @(posedge Clk);
        exp_q.push_back(expv);
        #1;
        InValid    = 1'b0;
        InMantissa = 25'($urandom);
        InExponent = 8'($urandom);
        for (int k = 1; k <= 3; k++) begin
            @(negedge Clk);
            chk("latency_valid", OutValid, (k == 3) ? 1 : 0);
            chk("busy_in_ready", InReady, 0);
        end
        for (int k = 0; k < hold; k++) begin
            InValid    = 1'b1;
            InMantissa = 25'($urandom);
            InExponent = 8'($urandom);
            chk("hold_out", dut_out(), exp_q[0]);
            chk("hold_valid", OutValid, 1);
            chk("hold_in_ready", InReady, 0);
            @(negedge Clk);
        end
        InValid  = 1'b0;
        OutReady = 1'b1;
        chk("result", dut_out(), exp_q.pop_front());
        @(posedge Clk);
        #1;
        OutReady = 1'b0;
        @(negedge Clk);
        chk("after_xfer_valid", OutValid, 0);
        chk("after_xfer_ready", InReady, 1);
    endtask

    initial begin
        tbl[0]  = '{25'h0800000, 8'd127, 25'h0800000, 8'd127, 0, 0, 0, 0, 5'd0};
        tbl[1]  = '{25'h0000001, 8'd127, 25'h0800000, 8'd104, 0, 0, 0, 0, 5'd23};
        tbl[2]  = '{25'h1000001, 8'd127, 25'h0800000, 8'd128, 0, 0, 0, 1, 5'd0};
        tbl[3]  = '{25'h1000001, 8'd254, 25'h0000000, 8'd255, 0, 1, 0, 0, 5'd0};
        tbl[4]  = '{25'h0000100, 8'd5,   25'h0001000, 8'd0,   0, 0, 1, 0, 5'd4};
        tbl[5]  = '{25'h0000000, 8'd100, 25'h0000000, 8'd0,   1, 0, 0, 0, 5'd0};
        tbl[6]  = '{25'h0400000, 8'd1,   25'h0400000, 8'd0,   0, 0, 1, 0, 5'd0};
        tbl[7]  = '{25'h0400000, 8'd2,   25'h0800000, 8'd1,   0, 0, 0, 0, 5'd1};
        tbl[8]  = '{25'h1FFFFFE, 8'd10,  25'h0FFFFFF, 8'd11,  0, 0, 0, 0, 5'd0};
        tbl[9]  = '{25'h0800000, 8'd0,   25'h0800000, 8'd0,   0, 0, 1, 0, 5'd0};
        tbl[10] = '{25'h1000000, 8'd253, 25'h0800000, 8'd254, 0, 0, 0, 0, 5'd0};
        tbl[11] = '{25'h0000001, 8'd24,  25'h0800000, 8'd1,   0, 0, 0, 0, 5'd23};
        tbl[12] = '{25'h0000001, 8'd23,  25'h0400000, 8'd0,   0, 0, 1, 0, 5'd22};
        tbl[13] = '{25'h0123456, 8'd200, 25'h091A2B0, 8'd197, 0, 0, 0, 0, 5'd3};

        Reset      = 1'b1;
        InValid    = 1'b0;
        OutReady   = 1'b0;
        InMantissa = '0;
        InExponent = '0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        chk("rst_out_valid", OutValid, 0);
        chk("rst_in_ready", InReady, 1);
        chk("rst_outputs", dut_out(), '0);
        chk("rst_shf_mantissa", ShfMantissa, '0);
        chk("rst_state", dbg_state, 0);

        // table vectors, back-to-back
        for (int i = 0; i < 14; i++) begin
            do_op(tbl[i].m, tbl[i].e, pack(tbl[i]), 0);
        end

        // long output stall with new requests ignored
        do_op(tbl[4].m, tbl[4].e, pack(tbl[4]), 10);
        chk("stall_state_idle", dbg_state, 0);
        chk("stall_queue_empty", exp_q.size(), 0);

        // reset while in SHIFT drops the result
        InValid    = 1'b1;
        InMantissa = 25'h0000001;
        InExponent = 8'd127;
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        chk("mid_state_shift", dbg_state, 2);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(negedge Clk);
        chk("mid_rst_out_valid", OutValid, 0);
        chk("mid_rst_in_ready", InReady, 1);
        chk("mid_rst_outputs", dut_out(), '0);
        chk("mid_rst_shf_mantissa", ShfMantissa, '0);
        do_op(tbl[13].m, tbl[13].e, pack(tbl[13]), 1);

        // random operations against the model
        for (int i = 0; i < 60; i++) begin
            logic [24:0] m;
            logic [7:0]  e;
            m = 25'($urandom) >> $urandom_range(0, 26);
            e = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 30)) : 8'($urandom_range(0, 254));
            do_op(m, e, model(m, e), $urandom_range(0, 3));
        end

        chk("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
